// File: rtl/fixedpoint_accumulator_sat.sv
// Saturating two's-complement frame accumulator with a two-state ACCUM/HOLD handshake FSM.
// Operands are summed (or subtracted) into acc until in_last; the frame result is then
// held on the output side until the consumer takes it.
module fixedpoint_accumulator_sat #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_op,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat
);

    localparam int unsigned LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic             r_sat;

    logic [0:0]       w_state_nxt;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_sat_nxt;

    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_gg;
    logic [WIDTH-1:0] w_pp;
    logic [WIDTH-1:0] w_gn;
    logic [WIDTH-1:0] w_pn;
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;
    logic [WIDTH-1:0] w_acc_upd;

    // Bit-level generate/propagate; subtraction is a + ~b + 1 with carry-in = in_op
    assign w_b = in_data ^ {WIDTH{in_op}};
    assign w_g = r_acc & w_b;
    assign w_p = r_acc ^ w_b;

    // Parallel-prefix carry lookahead: every carry derived from group G/P and the carry-in
    always_comb begin
        w_gg    = w_g;
        w_pp    = w_p;
        w_gn    = w_g;
        w_pn    = w_p;
        w_carry = '0;
        for (int l = 0; l < int'(LEVELS); l++) begin
            w_gn = w_gg;
            w_pn = w_pp;
            for (int i = (1 << l); i < int'(WIDTH); i++) begin
                w_gn[i] = w_gg[i] | (w_pp[i] & w_gg[i - (1 << l)]);
                w_pn[i] = w_pp[i] & w_pp[i - (1 << l)];
            end
            w_gg = w_gn;
            w_pp = w_pn;
        end
        w_carry[0] = in_op;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_carry[i+1] = w_gg[i] | (w_pp[i] & in_op);
        end
    end

    // Sum, overflow (carry into MSB vs carry out of MSB) and saturation toward acc's sign
    assign w_sum     = w_p ^ w_carry[WIDTH-1:0];
    assign w_ovf     = w_carry[WIDTH] ^ w_carry[WIDTH-1];
    assign w_acc_upd = w_ovf ? (r_acc[WIDTH-1] ? SAT_MIN : SAT_MAX) : w_sum;

    // Next-state and datapath update; clear overrides everything
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_count_nxt = r_count;
        w_sat_nxt   = r_sat;
        if (clear) begin
            w_state_nxt = ST_ACCUM;
            w_acc_nxt   = '0;
            w_count_nxt = '0;
            w_sat_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (in_valid) begin
                        w_acc_nxt   = w_acc_upd;
                        w_count_nxt = (r_count == CNT_MAX) ? r_count : r_count + CNT_W'(1);
                        w_sat_nxt   = r_sat | w_ovf;
                        if (in_last) begin
                            w_state_nxt = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        w_state_nxt = ST_ACCUM;
                        w_acc_nxt   = '0;
                        w_count_nxt = '0;
                        w_sat_nxt   = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = ST_ACCUM;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACCUM;
            r_acc   <= '0;
            r_count <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_count <= w_count_nxt;
            r_sat   <= w_sat_nxt;
        end
    end

    // Handshake decoded straight from the state flop; result fields straight from registers
    assign in_ready  = (r_state == ST_ACCUM);
    assign out_valid = (r_state == ST_HOLD);
    assign out_data  = r_acc;
    assign out_count = r_count;
    assign out_sat   = r_sat;

endmodule

// File: tb/tb_fixedpoint_accumulator_sat.sv
// Bench for fixedpoint_accumulator_sat: directed scenarios plus a randomized run against
// an integer-arithmetic frame model.
module tb_fixedpoint_accumulator_sat;

    localparam int W  = 16;
    localparam int CW = 8;
    localparam int MAXV = (1 << (W - 1)) - 1;
    localparam int MINV = -(1 << (W - 1));
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_op;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] out_count;
    logic          out_sat;

    int n_cmp = 0;
    int n_err = 0;

    // frame model: plain integers, clamped to the signed range
    int m_acc  = 0;
    int m_cnt  = 0;
    bit m_sat  = 1'b0;
    bit m_hold = 1'b0;

    fixedpoint_accumulator_sat #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic model_zero();
        m_acc = 0; m_cnt = 0; m_sat = 1'b0; m_hold = 1'b0;
    endtask

    // apply one cycle of inputs, advance the model, sample 1 time unit after the edge
    task automatic cyc(input bit v, input logic [W-1:0] d, input bit op, input bit l,
                       input bit ordy, input bit clr);
        int t;
        in_valid = v; in_data = d; in_op = op; in_last = l; out_ready = ordy; clear = clr;
        if (clr) begin
            model_zero();
        end else if (!m_hold) begin
            if (v) begin
                t = op ? m_acc - int'($signed(d)) : m_acc + int'($signed(d));
                if (t > MAXV) begin t = MAXV; m_sat = 1'b1; end
                if (t < MINV) begin t = MINV; m_sat = 1'b1; end
                m_acc = t;
                m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
                if (l) m_hold = 1'b1;
            end
        end else if (ordy) begin
            model_zero();
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0; clear = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid); end
        n_cmp++; if (out_data !== '0 || out_count !== '0 || out_sat !== 1'b0) begin n_err++;
            $display("FAIL reset_out: data=%h count=%0d sat=%b required 0/0/0", out_data, out_count, out_sat); end
        @(negedge clk);
        rst_n = 1'b1;
        model_zero();
    endtask

    task automatic test_add_seq();
        cyc(1, 16'h0100, 0, 0, 0, 0);
        cyc(1, 16'h0200, 0, 0, 0, 0);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++;
            $display("FAIL add_early_valid: out_valid=%b required 0", out_valid); end
        cyc(1, 16'h0080, 1, 1, 0, 0);
        n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++;
            $display("FAIL add_valid: out_valid=%b in_ready=%b required 1/0", out_valid, in_ready); end
        n_cmp++; if (out_data !== 16'h0280 || out_count !== 8'd3 || out_sat !== 1'b0) begin n_err++;
            $display("FAIL add_result: data=%h count=%0d sat=%b required 0280/3/0", out_data, out_count, out_sat); end
        cyc(0, 16'h0000, 0, 0, 1, 0);
        n_cmp++; if (out_valid !== 1'b0 || out_data !== '0 || out_count !== '0) begin n_err++;
            $display("FAIL add_consume: valid=%b data=%h count=%0d required 0/0/0", out_valid, out_data, out_count); end
    endtask

    task automatic test_overflow();
        cyc(1, 16'h7000, 0, 0, 0, 0);
        cyc(1, 16'h2000, 0, 1, 0, 0);
        n_cmp++; if (out_data !== 16'h7FFF || out_sat !== 1'b1 || out_valid !== 1'b1) begin n_err++;
            $display("FAIL pos_ovf: data=%h sat=%b valid=%b required 7FFF/1/1", out_data, out_sat, out_valid); end
        cyc(0, 16'h0000, 0, 0, 1, 0);
        cyc(1, 16'h7000, 1, 0, 0, 0);
        n_cmp++; if (out_data !== 16'h9000 || out_sat !== 1'b0) begin n_err++;
            $display("FAIL neg_step: data=%h sat=%b required 9000/0", out_data, out_sat); end
        cyc(1, 16'h2000, 1, 1, 0, 0);
        n_cmp++; if (out_data !== 16'h8000 || out_sat !== 1'b1 || out_count !== 8'd2) begin n_err++;
            $display("FAIL neg_ovf: data=%h sat=%b count=%0d required 8000/1/2", out_data, out_sat, out_count); end
        cyc(0, 16'h0000, 0, 0, 1, 0);
    endtask

    task automatic test_sub_min();
        cyc(1, 16'h8000, 1, 1, 0, 0);
        n_cmp++; if (out_data !== 16'h7FFF || out_sat !== 1'b1 || out_count !== 8'd1) begin n_err++;
            $display("FAIL sub_min: data=%h sat=%b count=%0d required 7FFF/1/1", out_data, out_sat, out_count); end
        cyc(0, 16'h0000, 0, 0, 1, 0);
    endtask

    task automatic test_backpressure();
        int bad = 0;
        cyc(1, 16'h7000, 0, 0, 0, 0);
        cyc(1, 16'h7000, 0, 1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(1, 16'($urandom), 1'($urandom), 0, 0, 0);
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'h7FFF ||
                out_count !== 8'd2 || out_sat !== 1'b1) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++;
            $display("FAIL bp_hold: %0d unstable cycles, required 0", bad); end
        cyc(1, 16'h0123, 0, 0, 1, 0);
        n_cmp++; if (out_valid !== 1'b0 || out_sat !== 1'b0 || out_count !== '0 || out_data !== '0) begin n_err++;
            $display("FAIL bp_release: valid=%b sat=%b count=%0d data=%h required 0/0/0/0",
                     out_valid, out_sat, out_count, out_data); end
        cyc(1, 16'h0005, 0, 1, 0, 0);
        n_cmp++; if (out_data !== 16'h0005 || out_count !== 8'd1 || out_sat !== 1'b0) begin n_err++;
            $display("FAIL bp_next: data=%h count=%0d sat=%b required 0005/1/0", out_data, out_count, out_sat); end
        cyc(0, 16'h0000, 0, 0, 1, 0);
    endtask

    task automatic test_clear();
        cyc(1, 16'h0100, 0, 0, 0, 0);
        cyc(1, 16'h0200, 0, 0, 0, 1);
        n_cmp++; if (out_data !== '0 || out_count !== '0 || in_ready !== 1'b1) begin n_err++;
            $display("FAIL clear_drop: data=%h count=%0d in_ready=%b required 0/0/1", out_data, out_count, in_ready); end
        cyc(1, 16'h0010, 0, 1, 0, 0);
        n_cmp++; if (out_data !== 16'h0010 || out_count !== 8'd1 || out_valid !== 1'b1) begin n_err++;
            $display("FAIL clear_next: data=%h count=%0d valid=%b required 0010/1/1", out_data, out_count, out_valid); end
        cyc(0, 16'h0000, 0, 0, 1, 0);
    endtask

    task automatic test_async_reset();
        cyc(1, 16'h1234, 0, 1, 0, 0);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++;
            $display("FAIL ares_pre: out_valid=%b required 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin n_err++;
            $display("FAIL ares_async: valid=%b data=%h in_ready=%b required 0/0/1", out_valid, out_data, in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        model_zero();
        cyc(0, 16'h0000, 0, 0, 1, 0);
        n_cmp++; if (out_valid !== 1'b0 || out_count !== '0) begin n_err++;
            $display("FAIL ares_after: valid=%b count=%0d required 0/0", out_valid, out_count); end
    endtask

    task automatic test_count_sat();
        cyc(0, 16'h0000, 0, 0, 0, 1);
        for (int k = 0; k < 299; k++) cyc(1, 16'h0000, 0, 0, 0, 0);
        cyc(1, 16'h0001, 0, 1, 0, 0);
        n_cmp++; if (out_count !== 8'd255 || out_data !== 16'h0001 || out_valid !== 1'b1) begin n_err++;
            $display("FAIL count_sat: count=%0d data=%h valid=%b required 255/0001/1", out_count, out_data, out_valid); end
        cyc(0, 16'h0000, 0, 0, 1, 0);
    endtask

    task automatic test_back_to_back();
        bit v, op, l, ordy, clr;
        logic [W-1:0] d;
        int errs_before;
        for (int k = 0; k < 600; k++) begin
            v    = ($urandom_range(0, 4) != 0);
            d    = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            op   = 1'($urandom);
            l    = ($urandom_range(0, 5) == 0);
            ordy = ($urandom_range(0, 2) != 0);
            clr  = ($urandom_range(0, 50) == 0);
            errs_before = n_err;
            cyc(v, d, op, l, ordy, clr);
            n_cmp++; if (out_valid !== m_hold || in_ready !== !m_hold) begin n_err++;
                $display("FAIL b2b_hs[%0d]: valid=%b in_ready=%b required %b/%b", k, out_valid, in_ready, m_hold, !m_hold); end
            n_cmp++; if (out_data !== W'(m_acc)) begin n_err++;
                $display("FAIL b2b_data[%0d]: got %h required %h", k, out_data, W'(m_acc)); end
            n_cmp++; if (out_count !== CW'(m_cnt) || out_sat !== m_sat) begin n_err++;
                $display("FAIL b2b_cnt_sat[%0d]: count=%0d sat=%b required %0d/%b", k, out_count, out_sat, m_cnt, m_sat); end
            if (n_err - errs_before > 0 && n_err > 30) begin
                $display("FAIL b2b_abort: too many errors, stopping random run");
                break;
            end
        end
        cyc(0, 16'h0000, 0, 0, 0, 1);
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        in_op = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        test_reset();
        test_add_seq();
        test_overflow();
        test_sub_min();
        test_backpressure();
        test_clear();
        test_async_reset();
        test_count_sat();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
